uart_rx: RTL

- 8N1 UART receiver for the board's UART_RXD pin; the receive-side counterpart of the serial transmit path on UART_TXD.
- Oversamples the asynchronous serial line, reassembles bytes LSB first, and presents each byte on a valid/ack handshake.
- Runs on CLOCK_50 and feeds display and LED logic in the top level.

---
 rtl/uart_rx_if.sv | 17 +
 rtl/uart_rx.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input and byte handshake bundle for uart_rx
// Signals: iRXD serial line (idle high), iACK consumer took oDATA,
//   oDATA received byte, oVALID byte pending, oFRAME_ERR/oOVERRUN/oPARITY_ERR
//   one-cycle pulses, oBUSY receiver not idle.
// master: the side driving the line and acknowledging; slave: the receiver.
interface uart_rx_if;
    logic       iRXD;
    logic       iACK;
    logic [7:0] oDATA;
    logic       oVALID;
    logic       oFRAME_ERR;
    logic       oOVERRUN;
    logic       oBUSY;
    logic       oPARITY_ERR;
    modport master (output iRXD, iACK, input oDATA, oVALID, oFRAME_ERR, oOVERRUN, oBUSY, oPARITY_ERR);
    modport slave  (input iRXD, iACK, output oDATA, oVALID, oFRAME_ERR, oOVERRUN, oBUSY, oPARITY_ERR);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with oversampling, 2-of-3 majority vote and valid/ack output
// Ports: iCLK clock; iRST asynchronous active-high reset; bus (uart_rx_if.slave)
//   carries iRXD, iACK, oDATA, oVALID, oFRAME_ERR, oOVERRUN, oBUSY, oPARITY_ERR.
// Defining UART_RX_PARITY_EN adds one even-parity bit after the data bits.
module uart_rx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input logic      iCLK,
    input logic      iRST,
    uart_rx_if.slave bus
);
    localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DW       = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int OW       = $clog2(OVERSAMPLE);
    localparam int MID      = OVERSAMPLE / 2;

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, BREAK
`ifdef UART_RX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t        state, nxt;
    logic          rx_s1, rx_s2, rx_prev;
    logic          fall, start_go, tick, decide, maj;
    logic          deliver, ferr, shift_en;
    logic [DW-1:0] div_cnt;
    logic [OW-1:0] os_cnt;
    logic [2:0]    bit_cnt;
    logic [1:0]    samp;
    logic [7:0]    shift;
`ifdef UART_RX_PARITY_EN
    logic          par_chk, par_bad;
`endif

    assign fall      = rx_prev & ~rx_s2;
    assign start_go  = (state == IDLE) && fall;
    assign tick      = (div_cnt == DW'(TICK_DIV - 1));
    assign decide    = tick && (os_cnt == OW'(MID + 1));
    // the two earlier mid-bit samples vote together with the line at the decision tick
    assign maj       = (samp[0] & samp[1]) | (samp[0] & rx_s2) | (samp[1] & rx_s2);
    assign bus.oBUSY = (state != IDLE);

    // rx_prev is one more stage so a 1->0 transition can be seen on the synchronized line
    always_ff @(posedge iCLK or posedge iRST)
        if (iRST) {rx_s1, rx_s2, rx_prev} <= 3'b111;
        else {rx_s1, rx_s2, rx_prev} <= {bus.iRXD, rx_s1, rx_s2};

    // the tick divider restarts on the start edge so bit centres line up with it
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            div_cnt <= '0;
            os_cnt  <= '0;
            samp    <= '0;
        end else begin
            div_cnt <= (start_go || tick) ? '0 : div_cnt + 1'b1;
            os_cnt  <= (state == IDLE) ? '0 : !tick ? os_cnt :
                       (os_cnt == OW'(OVERSAMPLE - 1)) ? '0 : os_cnt + 1'b1;
            if (tick && os_cnt == OW'(MID - 1)) samp[0] <= rx_s2;
            if (tick && os_cnt == OW'(MID)) samp[1] <= rx_s2;
        end
    end

    always_ff @(posedge iCLK or posedge iRST)
        if (iRST) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt      = state;
        deliver  = 1'b0;
        ferr     = 1'b0;
        shift_en = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_chk  = 1'b0;
`endif
        case (state)
            IDLE:  nxt = fall ? START : IDLE;
            START: nxt = !decide ? START : maj ? IDLE : DATA;
            DATA: begin
                shift_en = decide;
`ifdef UART_RX_PARITY_EN
                if (decide && bit_cnt == 3'd7) nxt = PARITY;
`else
                if (decide && bit_cnt == 3'd7) nxt = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                par_chk = decide;
                nxt     = decide ? STOP : PARITY;
            end
`endif
            // leaving at mid stop bit leaves half a bit to catch a back-to-back start edge
            STOP: begin
                deliver = decide & maj;
                ferr    = decide & ~maj;
                nxt     = !decide ? STOP : maj ? IDLE : BREAK;
            end
            BREAK:   nxt = rx_s2 ? IDLE : BREAK;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            bit_cnt        <= '0;
            shift          <= '0;
            bus.oDATA      <= '0;
            bus.oVALID     <= 1'b0;
            bus.oFRAME_ERR <= 1'b0;
            bus.oOVERRUN   <= 1'b0;
        end else begin
            if (start_go) bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
            if (shift_en) shift <= {maj, shift[7:1]};
            if (deliver) bus.oDATA <= shift;
            // a byte landing with iACK wins over the ack, so oVALID stays set
            bus.oVALID     <= deliver | (bus.oVALID & ~bus.iACK);
            bus.oFRAME_ERR <= ferr;
            bus.oOVERRUN   <= deliver & bus.oVALID & ~bus.iACK;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            par_bad         <= 1'b0;
            bus.oPARITY_ERR <= 1'b0;
        end else begin
            if (par_chk) par_bad <= maj ^ (^shift);
            bus.oPARITY_ERR <= deliver & par_bad;
        end
    end
`else
    assign bus.oPARITY_ERR = 1'b0;
`endif
endmodule
